// File: rtl/rv32i_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: stage enables/flushes, halt/drain/resume
// and stale-fetch discard. Define RV32I_PIPE_PERF_EN to build the stall/flush counters.
module rv32i_pipe_ctrl #(
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hz_stall,
  input  logic        br_taken,
  input  logic        jal_id,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_en,
  output logic        em_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYC - 1);

  state_e     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       drop_q, drop_d;
  logic       frozen_s, early_s;
  logic       pc_en_s, fd_en_s, de_en_s, em_en_s, mw_en_s, fd_flush_s, de_flush_s;

  // A pending data access stalls every stage; HALTED has no traffic to wait for.
  assign frozen_s = dmem_req & ~dmem_ready & (state_q != ST_HALTED);

  // Next-state and strobe decode.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    drop_d      = drop_q;
    early_s     = 1'b0;
    pc_en_s     = 1'b0;
    fd_en_s     = 1'b0;
    de_en_s     = 1'b0;
    em_en_s     = 1'b0;
    mw_en_s     = 1'b0;
    fd_flush_s  = 1'b0;
    de_flush_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!frozen_s) begin
          pc_en_s = 1'b1;
          fd_en_s = 1'b1;
          de_en_s = 1'b1;
          em_en_s = 1'b1;
          mw_en_s = 1'b1;
          if (drop_q && imem_ready) begin
            pc_en_s    = 1'b0;
            fd_flush_s = 1'b1;
            drop_d     = 1'b0;
            early_s    = 1'b1;
          end else if (br_taken) begin
            fd_flush_s = 1'b1;
            de_flush_s = 1'b1;
            drop_d     = drop_q | ~imem_ready;
            early_s    = 1'b1;
          end else if (hz_stall) begin
            pc_en_s    = 1'b0;
            fd_en_s    = 1'b0;
            de_flush_s = 1'b1;
            early_s    = 1'b1;
          end else if (jal_id) begin
            // The in-flight fetch of the old PC cannot be cancelled; remember to drop it.
            fd_flush_s = 1'b1;
            drop_d     = drop_q | ~imem_ready;
          end else if (!imem_ready) begin
            pc_en_s    = 1'b0;
            fd_flush_s = 1'b1;
          end else begin
            pc_en_s    = 1'b1;
          end
          if (halt_req && !early_s) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end else begin
            state_d     = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!frozen_s) begin
          pc_en_s    = br_taken;
          fd_flush_s = br_taken;
          de_en_s    = 1'b1;
          de_flush_s = 1'b1;
          em_en_s    = 1'b1;
          mw_en_s    = 1'b1;
          if (drain_cnt_q == 2'd0) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - 2'd1;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        if (resume_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign pc_en    = rst_n & pc_en_s;
  assign fd_en    = rst_n & fd_en_s;
  assign de_en    = rst_n & de_en_s;
  assign em_en    = rst_n & em_en_s;
  assign mw_en    = rst_n & mw_en_s;
  assign fd_flush = rst_n & fd_flush_s;
  assign de_flush = rst_n & de_flush_s;
  assign halted   = rst_n & (state_q == ST_HALTED);

`ifdef RV32I_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        run_act_s;

  assign run_act_s = (state_q == ST_RUN) & ~frozen_s;

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (run_act_s && !pc_en_s) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (run_act_s && (fd_flush_s || de_flush_s)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Scoreboard bench for rv32i_pipe_ctrl: a behavioural model pushes expected strobes and
// counters per cycle; the DUT outputs are popped and compared on the falling edge.
module tb_rv32i_pipe_ctrl;
  localparam int unsigned DC = 3;
`ifdef RV32I_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Stimulus bits: {hz, br, jal, imr, dreq, drdy, hreq, res}
  localparam logic [7:0] HZ   = 8'b1000_0000;
  localparam logic [7:0] BR   = 8'b0100_0000;
  localparam logic [7:0] JAL  = 8'b0010_0000;
  localparam logic [7:0] IMR  = 8'b0001_0000;
  localparam logic [7:0] DREQ = 8'b0000_1000;
  localparam logic [7:0] DRDY = 8'b0000_0100;
  localparam logic [7:0] HREQ = 8'b0000_0010;
  localparam logic [7:0] RES  = 8'b0000_0001;
  localparam logic [7:0] NONE = 8'b0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hz_stall = 1'b0, br_taken = 1'b0, jal_id = 1'b0, imem_ready = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0, resume_req = 1'b0;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  rv32i_pipe_ctrl #(.DRAIN_CYC(DC)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .br_taken(br_taken), .jal_id(jal_id),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .resume_req(resume_req), .pc_en(pc_en), .fd_en(fd_en),
    .de_en(de_en), .em_en(em_en), .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [7:0]  strb;   // {pc, fd, de, em, mw, fd_flush, de_flush, halted}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;
  exp_t sb_q[$];

  // Model state: 0=RUN 1=DRAIN 2=HALTED
  logic [1:0]  m_st, n_st, m_dcnt, n_dcnt;
  logic        m_drop, n_drop;
  logic [31:0] m_sc, m_fc, n_sc, n_fc;
  logic [7:0]  m_out;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 2'd0; m_dcnt = 2'd0; m_drop = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
  endtask

  task automatic model_eval();
    logic frz, pc, fd, ff, df, early;
    if (!rst_n) model_reset();
    n_st = m_st; n_dcnt = m_dcnt; n_drop = m_drop; n_sc = m_sc; n_fc = m_fc;
    m_out = 8'd0;
    frz = dmem_req && !dmem_ready && (m_st != 2'd2);
    pc = 1'b1; fd = 1'b1; ff = 1'b0; df = 1'b0; early = 1'b1;
    if (!rst_n || frz) begin
      m_out = 8'd0;
    end else if (m_st == 2'd0) begin
      if (m_drop && imem_ready) begin pc = 1'b0; ff = 1'b1; n_drop = 1'b0; end
      else if (br_taken) begin ff = 1'b1; df = 1'b1; if (!imem_ready) n_drop = 1'b1; end
      else if (hz_stall) begin pc = 1'b0; fd = 1'b0; df = 1'b1; end
      else begin
        early = 1'b0;
        if (jal_id) begin ff = 1'b1; if (!imem_ready) n_drop = 1'b1; end
        else if (!imem_ready) begin pc = 1'b0; ff = 1'b1; end
      end
      m_out = {pc, fd, 1'b1, 1'b1, 1'b1, ff, df, 1'b0};
      if (halt_req && !early) begin n_st = 2'd1; n_dcnt = 2'(DC - 1); end
      if (PERF && !pc) n_sc = m_sc + 32'd1;
      if (PERF && (ff || df)) n_fc = m_fc + 32'd1;
    end else if (m_st == 2'd1) begin
      m_out = {br_taken, 1'b0, 1'b1, 1'b1, 1'b1, br_taken, 1'b1, 1'b0};
      if (m_dcnt == 2'd0) n_st = 2'd2; else n_dcnt = m_dcnt - 2'd1;
    end else begin
      m_out = 8'b0000_0001;
      if (resume_req) n_st = 2'd0;
    end
  endtask

  // One clock cycle: drive, predict, compare on the falling edge, advance the model.
  task automatic step(input string tag, input logic [7:0] v);
    exp_t e;
    {hz_stall, br_taken, jal_id, imem_ready, dmem_req, dmem_ready, halt_req, resume_req} = v;
    #1;
    model_eval();
    sb_q.push_back('{tag, m_out, m_sc, m_fc});
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq({e.tag, ".strb"}, {24'd0, pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted},
             {24'd0, e.strb});
    check_eq({e.tag, ".stall_cnt"}, stall_cnt, e.sc);
    check_eq({e.tag, ".flush_cnt"}, flush_cnt, e.fc);
    @(posedge clk);
    if (rst_n) begin
      m_st = n_st; m_dcnt = n_dcnt; m_drop = n_drop; m_sc = n_sc; m_fc = n_fc;
    end
    #1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    step("rst0", IMR | BR | HZ);
    step("rst1", IMR | HREQ);
    rst_n = 1'b1;
    step("idle0", IMR);
    step("idle1", IMR);
    // Single-cycle hazard stall
    step("hz", IMR | HZ);
    step("hz_after", IMR);
    check_eq("hz_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
    // Branch wins over stall
    step("br_hz", IMR | BR | HZ);
    check_eq("br_hz_flush_cnt", flush_cnt, PERF ? 32'd2 : 32'd0);
    check_eq("br_hz_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
    // JAL with fetch outstanding, stale response dropped
    step("jal_nr", JAL);
    step("wait_nr", NONE);
    step("drop_srv", IMR);
    step("after_drop", IMR);
    // Data-memory freeze hides a branch until ready
    step("frz0", IMR | BR | DREQ);
    step("frz1", IMR | BR | DREQ);
    step("frz2", IMR | BR | DREQ);
    step("frz_rel", IMR | BR | DREQ | DRDY);
    // Halt rejected under stall, then accepted with a freeze inside DRAIN
    step("halt_hz", IMR | HZ | HREQ);
    step("halt_go", IMR | HREQ);
    step("drain0", IMR | HREQ | JAL | HZ);
    step("frz_drain", IMR | DREQ);
    step("drain1", IMR);
    step("drain2_br", IMR | BR);
    step("halted0", IMR | HREQ);
    check_eq("halted_lat", {31'd0, halted}, 32'd1);
    step("halted1", IMR | HZ | DREQ);
    step("resume", IMR | RES);
    step("run_again", IMR);
    // Stale-fetch flag survives halt and is served after resume
    step("jal_halt", JAL | HREQ);
    step("d_a", NONE);
    step("d_b", NONE);
    step("d_c", NONE);
    step("h_res", RES);
    step("drop_post_res", IMR);
    step("idle2", IMR);
    // Reset in the middle of DRAIN
    step("halt2", IMR | HREQ);
    step("drain_r", IMR);
    rst_n = 1'b0;
    step("rst_mid", IMR | BR);
    rst_n = 1'b1;
    step("post_rst", IMR);
    check_eq("post_rst_stall", stall_cnt, 32'd0);
    check_eq("post_rst_halted", {31'd0, halted}, 32'd0);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_pipe_ctrl.md
# rv32i_pipe_ctrl

Central pipeline sequencer for the 5-stage RV32I core. It merges the hazard unit's stall request, the EX-stage branch redirect, the ID-stage jump redirect, and the instruction/data memory ready handshakes into per-stage enable and flush strobes. It also runs a halt/drain/resume state machine and discards stale fetch responses after a redirect. It sits between the hazard unit and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
Parameters:
- DRAIN_CYC, 3, cycles spent in DRAIN to empty DE/EM/MW (1..3).

Ports (per bullet: name, direction, width, meaning):
- clk, in, 1, core clock; all state updates on rising edge.
- rst_n, in, 1, reset. Asynchronous assert, active-low. This polarity and synchronicity are fixed.
- hz_stall, in, 1, stall request from the hazard unit (load-use or JALR dependence).
- br_taken, in, 1, branch or JALR in EX resolved taken; the PC mux selects the target.
- jal_id, in, 1, JAL decoded in ID; the PC mux selects the target.
- imem_ready, in, 1, instruction for the current PC is valid this cycle.
- dmem_req, in, 1, load/store in MEM is accessing memory.
- dmem_ready, in, 1, data access completes this cycle.
- halt_req, in, 1, level request to halt the core.
- resume_req, in, 1, single-cycle pulse that leaves HALTED.
- pc_en, out, 1, PC register load enable.
- fd_en, de_en, em_en, mw_en, out, 1 each, pipeline register enables.
- fd_flush, de_flush, out, 1 each, load a bubble (NOP, valid=0) into IF/ID or ID/EX. A flush overrides the matching enable.
- halted, out, 1, high in HALTED.
- stall_cnt, flush_cnt, out, 32 each, performance counters (see Configuration).

## Operation
- Registered state: `state` ∈ {RUN=2'd0, DRAIN=2'd1, HALTED=2'd2}; `drain_cnt` (2 bits); `drop` (1 bit).
- All strobes are combinational from the registered state and the current inputs.
- While rst_n=0, every enable and flush output is forced to 0.
- **Freeze.** Condition: dmem_req & !dmem_ready, in RUN or DRAIN.
  - All enables are 0 and all flushes are 0.
  - No registered state changes.
- **RUN, not frozen.** Rules are evaluated in priority order; the first match wins. Enables not named are 1.
  1. drop & imem_ready: pc_en=0, fd_flush=1, drop clears. This discards the stale response; the target is re-fetched.
  2. br_taken: pc_en=1, fd_flush=1, de_flush=1.
  3. hz_stall: pc_en=0, fd_en=0, de_flush=1.
  4. jal_id: pc_en=1, fd_flush=1.
  5. !imem_ready: pc_en=0, fd_flush=1.
  6. Otherwise all enables are 1.
- **Stale-fetch flag.** If rule 2 or 4 fires while imem_ready=0, drop sets next cycle. The outstanding fetch cannot be cancelled.
- **Halt entry.** halt_req=1 in an unfrozen RUN cycle in which none of rules 1–3 fires: the normal RUN strobes apply, then the block enters DRAIN with drain_cnt=DRAIN_CYC-1.
- **DRAIN, not frozen.**
  - Base strobes: pc_en=0, fd_en=0 (the IF/ID instruction is held and re-issues after resume), de_flush=1, em_en=mw_en=1.
  - If br_taken: additionally pc_en=1 and fd_flush=1.
  - jal_id, hz_stall and imem_ready are ignored.
  - drain_cnt decrements each cycle. At drain_cnt=0, the next state is HALTED.
- **HALTED.**
  - All enables 0, all flushes 0, halted=1.
  - resume_req moves the block to RUN next cycle.
  - halt_req is ignored in HALTED.
- The drop flag persists across DRAIN/HALTED and is served by rule 1 after resume.

## Timing
- Reset values: state=RUN, drain_cnt=0, drop=0, stall_cnt=0, flush_cnt=0, halted=0. Strobes are 0 during reset.
- Zero-cycle latency: strobes respond combinationally in the same cycle as their inputs.
- Halt latency: halt_req accepted in cycle N → DRAIN for cycles N+1 … N+DRAIN_CYC → halted=1 from N+DRAIN_CYC+1. Each freeze cycle adds one cycle to this latency.
- Resume latency: resume_req in cycle M → RUN from M+1.
- Reset asserted mid-DRAIN or while drop=1 returns everything to reset values immediately.
- br_taken and hz_stall together: rule 2 wins, and de_flush removes the stalled consumer's partner.

## Configuration
- RV32I_PIPE_PERF_EN defined:
  - stall_cnt increments on every cycle with pc_en=0 in RUN.
  - flush_cnt increments on every cycle with fd_flush|de_flush in RUN.
  - Both counters wrap modulo 2^32.
- RV32I_PIPE_PERF_EN undefined: no counter flops are instantiated, and stall_cnt and flush_cnt are tied to 32'd0.

## Test plan
- hz_stall=1 for one cycle, other inputs idle → pc_en=0, fd_en=0, de_flush=1; next cycle all enables 1, stall_cnt=1.
- br_taken=1 with hz_stall=1 → pc_en=1, fd_flush=1, de_flush=1; stall_cnt unchanged, flush_cnt +1.
- jal_id=1 with imem_ready=0, then imem_ready=1 two cycles later → drop=1 in between; on the ready cycle pc_en=0 and fd_flush=1; the following cycle is normal.
- dmem_req=1 with dmem_ready=0 for 3 cycles while br_taken=1 → all strobes 0 for 3 cycles; on the ready cycle the branch flush pattern appears.
- halt_req in cycle 10, DRAIN_CYC=3, dmem freeze in cycle 12 → DRAIN cycles 11–14, halted=1 from 15; resume_req in 20 → RUN at 21 and the held IF/ID instruction issues.
- rst_n low in the middle of DRAIN → outputs 0 at once; after release the block is in RUN and the counters read 0.
